// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: register-index and address widths plus the
// hazard controller state encoding.
package cpu_pipe_pkg;

   localparam int REG_W  = 5;
   localparam int ADDR_W = 32;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      BR2   = 2'd1,
      IWAIT = 2'd2
   } hazState_t;

endpackage : cpu_pipe_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard controller performance counters.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (inc && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule : sat_counter

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch-operand bubbles, ID-stage
// redirects with I-cache wait, D-cache freeze, and stall/redirect counters.
module hazard_ctrl
   import cpu_pipe_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_W-1:0]  IFID_RegRs,
   input  logic [REG_W-1:0]  IFID_RegRt,
   input  logic              ID_Branch,
   input  logic              ID_Redirect,
   input  logic [ADDR_W-1:0] ID_Target,
   input  logic              IDEX_MemRead,
   input  logic              IDEX_RegWrite,
   input  logic [REG_W-1:0]  IDEX_RegRd,
   input  logic              ICache_stall,
   input  logic              DCache_stall,
   output logic              PC_Write,
   output logic              PC_Sel,
   output logic [ADDR_W-1:0] PC_Next,
   output logic              IFID_Write,
   output logic              IFID_Flush,
   output logic              IDEX_Flush,
   output logic              Back_Write,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  redirect_cnt
);

   hazState_t         stateReg, stateNext;
   logic [ADDR_W-1:0] tgtReg, tgtNext;
   logic              regHit, loadUse, branchExHit;

   assign regHit      = (IDEX_RegRd != '0) &&
                        ((IDEX_RegRd == IFID_RegRs) || (IDEX_RegRd == IFID_RegRt));
   assign loadUse     = IDEX_MemRead && regHit;
   assign branchExHit = ID_Branch && IDEX_RegWrite && !IDEX_MemRead && regHit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateReg <= RUN;
         tgtReg   <= '0;
      end else begin
         stateReg <= stateNext;
         tgtReg   <= tgtNext;
      end
   end

   always_comb begin
      stateNext  = stateReg;
      tgtNext    = tgtReg;
      PC_Write   = 1'b0;
      PC_Sel     = 1'b0;
      IFID_Write = 1'b0;
      IFID_Flush = 1'b0;
      IDEX_Flush = 1'b0;
      Back_Write = 1'b0;
      // A D-cache miss freezes the whole pipe, controller state included
      if (!rst && !DCache_stall) begin
         Back_Write = 1'b1;
         unique case (stateReg)
            RUN: begin
               if (loadUse || branchExHit) begin
                  IDEX_Flush = 1'b1;
                  stateNext  = (loadUse && ID_Branch) ? BR2 : RUN;
               end else if (ID_Redirect && !ICache_stall) begin
                  PC_Sel     = 1'b1;
                  PC_Write   = 1'b1;
                  IFID_Write = 1'b1;
                  IFID_Flush = 1'b1;
               end else if (ID_Redirect) begin
                  IFID_Write = 1'b1;
                  IFID_Flush = 1'b1;
                  tgtNext    = ID_Target;
                  stateNext  = IWAIT;
               end else if (ICache_stall) begin
                  IFID_Write = 1'b1;
                  IFID_Flush = 1'b1;
               end else begin
                  PC_Write   = 1'b1;
                  IFID_Write = 1'b1;
               end
            end
            BR2: begin
               IDEX_Flush = 1'b1;
               stateNext  = RUN;
            end
            IWAIT: begin
               IFID_Write = 1'b1;
               IFID_Flush = 1'b1;
               if (!ICache_stall) begin
                  PC_Sel    = 1'b1;
                  PC_Write  = 1'b1;
                  stateNext = RUN;
               end
            end
            default: stateNext = RUN;
         endcase
      end
   end

   // Only a pending I-cache redirect sources the captured target
   assign PC_Next = (PC_Sel && (stateReg == IWAIT)) ? tgtReg : ID_Target;

   sat_counter #(.CNT_W(CNT_W)) stallCounter (
      .clk (clk),
      .rst (rst),
      .inc (!PC_Write),
      .cnt (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) redirectCounter (
      .clk (clk),
      .rst (rst),
      .inc (PC_Sel),
      .cnt (redirect_cnt)
   );

endmodule : hazard_ctrl
